vga_timing_generator: RTL and testbench

- Produces raster scan coordinates (row, col) for the pixel-colour logic and sends the returned colour to the VGA connector with correct blanking and sync.
- Sits between the board clock and the VGA pins and feeds the combinational drawer, which computes colour from row/col in the same cycle.
- Default timing is 640x480@60 Hz, with a 25 MHz pixel rate derived from a 50 MHz clk.

---
 rtl/vga_timing_generator.sv | 198 +++++++++++++++++++
 tb/tb_vga_timing_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Raster timing generator for a VGA connector. It produces the current scan
// coordinates (row, col) for a combinational pixel-colour "drawer". The colour
// the drawer returns is registered, together with blanking and sync, to
// drive the DAC and sync pins.
//
// A clock divider turns clk into a pixel rate. One pixel is produced every
// CLK_DIV clk cycles, and pixel_tick marks the last clk of each pixel period.
// The horizontal and vertical counters advance on pixel_tick. The output
// stage samples the pre-increment counters on the same tick. The pins
// therefore lag row/col by exactly one pixel, and sync stays aligned with
// colour.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   pixel_red       4-bit red returned by the drawer for the current row/col
//   pixel_green     4-bit green, same timing as pixel_red
//   pixel_blue      4-bit blue, same timing as pixel_red
//   row             current visible line, 0 while blanked (combinational)
//   col             current visible pixel, 0 while blanked (combinational)
//   pixel_tick      one-clk strobe, high on the clk where the pixel advances
//   vga_hs          registered horizontal sync
//   vga_vs          registered vertical sync
//   vga_r/g/b       registered colour to the DAC, 0 while blanked
//   display_enable  registered, high while the registered pixel is visible
//   frame_start     one-clk pulse when the registered pixel is (0,0)
// ---------------------------------------------------------------------------
module vga_timing_generator #(
  parameter int   CLK_DIV     = 2,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pixel_red,
  input  logic [3:0]  pixel_green,
  input  logic [3:0]  pixel_blue,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        pixel_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        display_enable,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The divider needs at least one bit, even when CLK_DIV is 1 and it
  // never leaves zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // Divider and raster counters
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [10:0]      h_cnt_reg, h_cnt_next;
  logic [10:0]      v_cnt_reg, v_cnt_next;

  logic h_last;
  logic v_last;

  assign pixel_tick = (div_cnt_reg == DIV_LAST);
  assign h_last     = (h_cnt_reg == H_LAST);
  assign v_last     = (v_cnt_reg == V_LAST);

  // Wrapping h and v are decided together from the same tick. The last
  // pixel of the frame therefore moves straight to (0,0) in one step.
  always_comb begin
    div_cnt_next = div_cnt_reg;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    if (pixel_tick) begin
      div_cnt_next = '0;
      if (h_last) begin
        h_cnt_next = '0;
        v_cnt_next = v_last ? 11'd0 : v_cnt_reg + 11'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 11'd1;
      end
    end else begin
      div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Visible window, coordinates for the drawer, and sync windows
  // -------------------------------------------------------------------------
  logic active;
  logic hs_raw;
  logic vs_raw;

  assign active = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);

  // Blanked coordinates collapse to 0, so the drawer never sees an index
  // outside the visible area.
  assign row = active ? {21'd0, v_cnt_reg} : 32'd0;
  assign col = active ? {21'd0, h_cnt_reg} : 32'd0;

  assign hs_raw = ((h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_raw = ((v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // -------------------------------------------------------------------------
  // Output stage: one register stage shared by sync, enable and colour
  // -------------------------------------------------------------------------
  logic hs_reg;
  logic vs_reg;
  logic de_reg;
  logic frame_start_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_reg          <= ~SYNC_ACTIVE;
      vs_reg          <= ~SYNC_ACTIVE;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      // frame_start lasts only one clk, even though the other outputs
      // hold for the whole pixel period.
      frame_start_reg <= 1'b0;
      if (pixel_tick) begin
        hs_reg          <= hs_raw;
        vs_reg          <= vs_raw;
        de_reg          <= active;
        frame_start_reg <= (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
      end
    end
  end

  // Colour channels, packed as {red, green, blue} with blue in the low
  // nibble. Each channel is a blanked register that loads only on a tick.
  logic [11:0] pixel_in;
  logic [11:0] rgb_out;

  assign pixel_in = {pixel_red, pixel_green, pixel_blue};

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [3:0] chan_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        chan_reg <= 4'h0;
      end else if (pixel_tick) begin
        chan_reg <= active ? pixel_in[gi*4 +: 4] : 4'h0;
      end
    end

    assign rgb_out[gi*4 +: 4] = chan_reg;
  end

  assign vga_r          = rgb_out[11:8];
  assign vga_g          = rgb_out[7:4];
  assign vga_b          = rgb_out[3:0];
  assign vga_hs         = hs_reg;
  assign vga_vs         = vs_reg;
  assign display_enable = de_reg;
  assign frame_start    = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// This bench runs three generators side by side on one clock:
//   a : default 640x480 timing with CLK_DIV=2. Its drawer returns
//       {row[3:0], col[3:0], 4'hA}.
//   b : CLK_DIV=3 with a small geometry and active-high sync. Colour is
//       random on every clk.
//   c : CLK_DIV=1 with the tiny 4/1/1/1 x 3/1/1/1 geometry. Colour is
//       random on every clk.
//
// The reference model counts the clk edges since reset was last sampled.
// From that count it derives the pixel number, the raster position and the
// expected registered outputs with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

  localparam int NCYC  = 13000;
  localparam int MID_N = (2 * 800 + 400) * 2;   // a: row 2, col 400

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- instance a ----------------
  logic        reset_a;
  logic [3:0]  pr_a, pg_a, pb_a;
  logic [31:0] row_a, col_a;
  logic        tick_a, hs_a, vs_a, de_a, fs_a;
  logic [3:0]  r_a, g_a, b_a;

  assign pr_a = row_a[3:0];
  assign pg_a = col_a[3:0];
  assign pb_a = 4'hA;

  vga_timing_generator u_a (
    .clk(clk), .reset(reset_a),
    .pixel_red(pr_a), .pixel_green(pg_a), .pixel_blue(pb_a),
    .row(row_a), .col(col_a), .pixel_tick(tick_a),
    .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .display_enable(de_a), .frame_start(fs_a)
  );

  // ---------------- instance b ----------------
  logic        reset_b;
  logic [3:0]  pr_b, pg_b, pb_b;
  logic [31:0] row_b, col_b;
  logic        tick_b, hs_b, vs_b, de_b, fs_b;
  logic [3:0]  r_b, g_b, b_b;

  vga_timing_generator #(
    .CLK_DIV(3),
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE(1'b1)
  ) u_b (
    .clk(clk), .reset(reset_b),
    .pixel_red(pr_b), .pixel_green(pg_b), .pixel_blue(pb_b),
    .row(row_b), .col(col_b), .pixel_tick(tick_b),
    .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .display_enable(de_b), .frame_start(fs_b)
  );

  // ---------------- instance c ----------------
  logic        reset_c;
  logic [3:0]  pr_c, pg_c, pb_c;
  logic [31:0] row_c, col_c;
  logic        tick_c, hs_c, vs_c, de_c, fs_c;
  logic [3:0]  r_c, g_c, b_c;

  vga_timing_generator #(
    .CLK_DIV(1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE(1'b0)
  ) u_c (
    .clk(clk), .reset(reset_c),
    .pixel_red(pr_c), .pixel_green(pg_c), .pixel_blue(pb_c),
    .row(row_c), .col(col_c), .pixel_tick(tick_c),
    .vga_hs(hs_c), .vga_vs(vs_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
    .display_enable(de_c), .frame_start(fs_c)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected state after n clk edges without reset. cap is the colour that
  // was driven on the last tick. When drawer is set, the colour comes from
  // the registered pixel's coordinates.
  task automatic check_unit(
    input string tag, input int d,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input logic sa, input longint n, input logic [11:0] cap, input bit drawer,
    input logic [31:0] row, input logic [31:0] col, input logic tick,
    input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g,
    input logic [3:0] b, input logic de, input logic fs);
    longint ht, vt, p, h, v, q, hq, vq;
    bit     act, actq;
    logic   e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_rgb;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    p   = n / d;
    h   = p % ht;
    v   = (p / ht) % vt;
    act = (h < ha) && (v < va);
    check_eq({tag, ".row"},  64'(row), act ? 64'(v) : 64'd0);
    check_eq({tag, ".col"},  64'(col), act ? 64'(h) : 64'd0);
    check_eq({tag, ".tick"}, 64'(tick), 64'((n % d) == d - 1));
    if (p == 0) begin
      e_hs = ~sa; e_vs = ~sa; e_de = 1'b0; e_fs = 1'b0; e_rgb = 12'h000;
    end else begin
      q    = p - 1;
      hq   = q % ht;
      vq   = (q / ht) % vt;
      actq = (hq < ha) && (vq < va);
      e_hs = (hq >= ha + hf && hq < ha + hf + hsw) ? sa : ~sa;
      e_vs = (vq >= va + vf && vq < va + vf + vsw) ? sa : ~sa;
      e_de = actq;
      e_fs = ((n % d) == 0) && (hq == 0) && (vq == 0);
      if (!actq)       e_rgb = 12'h000;
      else if (drawer) e_rgb = {4'(vq), 4'(hq), 4'hA};
      else             e_rgb = cap;
      if (drawer && vq == 5 && hq == 7)
        check_eq({tag, ".rgb57"}, 64'({r, g, b}), 64'h57A);
    end
    check_eq({tag, ".hs"},  64'(hs), 64'(e_hs));
    check_eq({tag, ".vs"},  64'(vs), 64'(e_vs));
    check_eq({tag, ".de"},  64'(de), 64'(e_de));
    check_eq({tag, ".fs"},  64'(fs), 64'(e_fs));
    check_eq({tag, ".rgb"}, 64'({r, g, b}), 64'(e_rgb));
  endtask

  // ---------------- stimulus and model ----------------
  longint      n_a, n_b, n_c;
  logic [11:0] cap_b, cap_c;
  bit          mid_done;
  longint      fs_last_c;

  initial begin
    n_a = 0; n_b = 0; n_c = 0;
    cap_b = '0; cap_c = '0;
    mid_done = 1'b0;
    fs_last_c = -1;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    pr_b = '0; pg_b = '0; pb_b = '0;
    pr_c = '0; pg_c = '0; pb_c = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Drive inputs away from the active edge.
      reset_a = (cyc < 5);
      if (!mid_done && n_a == MID_N && cyc >= 5) begin
        reset_a  = 1'b1;
        mid_done = 1'b1;
      end
      reset_b = (cyc < 3) || ($urandom_range(0, 249) == 0);
      reset_c = (cyc < 3) || ($urandom_range(0, 249) == 0);
      {pr_b, pg_b, pb_b} = 12'($urandom);
      {pr_c, pg_c, pb_c} = 12'($urandom);

      @(posedge clk);
      if (reset_a) n_a = 0; else n_a++;
      if (reset_b) n_b = 0;
      else begin
        if (n_b % 3 == 2) cap_b = {pr_b, pg_b, pb_b};
        n_b++;
      end
      if (reset_c) begin
        n_c = 0;
        fs_last_c = -1;
      end else begin
        cap_c = {pr_c, pg_c, pb_c};
        n_c++;
      end

      @(negedge clk);
      check_unit("a", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n_a, 12'h000, 1'b1,
                 row_a, col_a, tick_a, hs_a, vs_a, r_a, g_a, b_a, de_a, fs_a);
      check_unit("b", 3, 10, 2, 3, 2, 6, 2, 2, 2, 1'b1, n_b, cap_b, 1'b0,
                 row_b, col_b, tick_b, hs_b, vs_b, r_b, g_b, b_b, de_b, fs_b);
      check_unit("c", 1, 4, 1, 1, 1, 3, 1, 1, 1, 1'b0, n_c, cap_c, 1'b0,
                 row_c, col_c, tick_c, hs_c, vs_c, r_c, g_c, b_c, de_c, fs_c);
      // Frames in c are 42 clk apart when no reset intervenes.
      if (fs_c === 1'b1) begin
        if (fs_last_c >= 0) check_eq("c.frame_period", 64'(cyc - fs_last_c), 64'd42);
        fs_last_c = cyc;
      end
    end

    check_eq("a.mid_reset_applied", 64'(mid_done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
